// File: rtl/freq_change_sequencer.sv
// Frequency-change sequencer: quiesces the memory controller, hands off to software
// for PLL reprogramming, waits for relock, and guards the whole sequence with a watchdog.
module freq_change_sequencer #(
  parameter int NB_FREQ     = 8,
  parameter int FIDX_W      = 5,
  parameter int QUIESCE_CYC = 4,
  parameter int WDT_CYC     = 64
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              start_freq_change_i,
  input  logic [FIDX_W-1:0] freq_index_i,
  input  logic              pll_freq_chng_done_i,
  input  logic              mc_idle_i,
  input  logic              pll_lock_i,
  output logic              freq_change_ready_o,
  output logic              freq_change_done_o,
  output logic              freq_change_error_o,
  output logic              watch_dog_timeout_o,
  output logic              pll_req_o,
  output logic [FIDX_W-1:0] pll_freq_sel_o,
  output logic [FIDX_W-1:0] cur_freq_index_o,
  output logic              busy_o
);

  localparam int Q_W   = (QUIESCE_CYC < 1) ? 1 : $clog2(QUIESCE_CYC + 1);
  localparam int WDT_W = (WDT_CYC < 2) ? 1 : $clog2(WDT_CYC + 1);
  localparam logic [Q_W-1:0]   Q_LAST    = Q_W'((QUIESCE_CYC > 0) ? QUIESCE_CYC - 1 : 0);
  localparam logic [WDT_W-1:0] WDT_LAST  = WDT_W'((WDT_CYC > 0) ? WDT_CYC - 1 : 0);
  localparam logic [WDT_W-1:0] WDT_MAX   = WDT_W'(WDT_CYC);
  localparam logic [FIDX_W:0]  NB_FREQ_L = (FIDX_W + 1)'(NB_FREQ);

  typedef enum logic [2:0] {
    S_IDLE, S_QUIESCE, S_READY, S_WAIT_PLL, S_RELOCK, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              start_q;
  logic              start_blk_q;
  logic [Q_W-1:0]    q_cnt_q, q_cnt_d;
  logic [WDT_W-1:0]  wdt_q, wdt_d;
  logic [FIDX_W-1:0] sel_q, sel_d;
  logic [FIDX_W-1:0] cur_q, cur_d;
  logic              timeout_d;
  logic              ready_q, done_q, err_q, wdt_to_q, pll_req_q, busy_q;
  logic              start_edge, idx_bad, active, wdt_hit;

  always_comb begin
    // A start level held across reset release is blocked for the first cycle.
    start_edge = start_freq_change_i & ~start_q & ~start_blk_q;
    idx_bad    = ({1'b0, freq_index_i} >= NB_FREQ_L);
    active     = (state_q inside {S_QUIESCE, S_READY, S_WAIT_PLL, S_RELOCK});
    wdt_hit    = active && (wdt_q >= WDT_LAST);

    state_d   = state_q;
    q_cnt_d   = q_cnt_q;
    wdt_d     = wdt_q;
    sel_d     = sel_q;
    cur_d     = cur_q;
    timeout_d = 1'b0;

    if (active && (wdt_q != WDT_MAX)) wdt_d = wdt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          if (idx_bad) begin
            state_d = S_ERR;
          end else if (freq_index_i == cur_q) begin
            // Latching the (equal) index keeps the DONE-cycle update of cur a no-op.
            sel_d   = freq_index_i;
            state_d = S_DONE;
          end else begin
            sel_d   = freq_index_i;
            q_cnt_d = '0;
            wdt_d   = '0;
            state_d = S_QUIESCE;
          end
        end
      end
      S_QUIESCE: begin
        if (q_cnt_q < Q_LAST) q_cnt_d = q_cnt_q + 1'b1;
        if ((q_cnt_q >= Q_LAST) && mc_idle_i) state_d = S_READY;
      end
      S_READY:    state_d = S_WAIT_PLL;
      S_WAIT_PLL: if (pll_freq_chng_done_i) state_d = S_RELOCK;
      S_RELOCK:   if (pll_lock_i) state_d = S_DONE;
      S_DONE: begin
        cur_d   = sel_q;
        state_d = S_IDLE;
      end
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // A completion in the expiry cycle takes priority over the watchdog.
    if (wdt_hit && (state_d != S_DONE)) begin
      state_d   = S_ERR;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      start_blk_q <= start_freq_change_i;
      q_cnt_q     <= '0;
      wdt_q       <= '0;
      sel_q       <= '0;
      cur_q       <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wdt_to_q    <= 1'b0;
      pll_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_freq_change_i;
      start_blk_q <= 1'b0;
      q_cnt_q     <= q_cnt_d;
      wdt_q       <= wdt_d;
      sel_q       <= sel_d;
      cur_q       <= cur_d;
      ready_q     <= (state_d == S_READY);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
      wdt_to_q    <= timeout_d;
      pll_req_q   <= (state_d == S_RELOCK);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign freq_change_ready_o = ready_q;
  assign freq_change_done_o  = done_q;
  assign freq_change_error_o = err_q;
  assign watch_dog_timeout_o = wdt_to_q;
  assign pll_req_o           = pll_req_q;
  assign pll_freq_sel_o      = sel_q;
  assign cur_freq_index_o    = cur_q;
  assign busy_o              = busy_q;

endmodule

// File: tb/tb_freq_change_sequencer.sv
// Bench for freq_change_sequencer: directed scenarios plus randomized sequences
// compared cycle by cycle against a closed-form timing model of each sequence.
module tb_freq_change_sequencer;

  localparam int NB_FREQ     = 8;
  localparam int FIDX_W      = 5;
  localparam int QUIESCE_CYC = 4;
  localparam int WDT_CYC     = 64;
  localparam int MAXT        = 256;

  // Output vector layout: {ready, done, error, timeout, pll_req, busy}
  localparam logic [5:0] V_READY = 6'b100000;
  localparam logic [5:0] V_DONE  = 6'b010000;
  localparam logic [5:0] V_ERR   = 6'b001000;
  localparam logic [5:0] V_TO    = 6'b000100;
  localparam logic [5:0] V_REQ   = 6'b000010;
  localparam logic [5:0] V_BUSY  = 6'b000001;

  logic              pclk_i = 1'b0;
  logic              prst_i;
  logic              start_freq_change_i;
  logic [FIDX_W-1:0] freq_index_i;
  logic              pll_freq_chng_done_i;
  logic              mc_idle_i;
  logic              pll_lock_i;
  logic              freq_change_ready_o;
  logic              freq_change_done_o;
  logic              freq_change_error_o;
  logic              watch_dog_timeout_o;
  logic              pll_req_o;
  logic [FIDX_W-1:0] pll_freq_sel_o;
  logic [FIDX_W-1:0] cur_freq_index_o;
  logic              busy_o;
  logic [5:0]        outv;

  logic [5:0] obs_v [MAXT];
  logic [5:0] exp_v [MAXT];
  int n_checks = 0;
  int n_pass   = 0;
  int m_cur    = 0;

  always #5 pclk_i = ~pclk_i;

  freq_change_sequencer #(
    .NB_FREQ(NB_FREQ), .FIDX_W(FIDX_W), .QUIESCE_CYC(QUIESCE_CYC), .WDT_CYC(WDT_CYC)
  ) dut (
    .pclk_i(pclk_i),
    .prst_i(prst_i),
    .start_freq_change_i(start_freq_change_i),
    .freq_index_i(freq_index_i),
    .pll_freq_chng_done_i(pll_freq_chng_done_i),
    .mc_idle_i(mc_idle_i),
    .pll_lock_i(pll_lock_i),
    .freq_change_ready_o(freq_change_ready_o),
    .freq_change_done_o(freq_change_done_o),
    .freq_change_error_o(freq_change_error_o),
    .watch_dog_timeout_o(watch_dog_timeout_o),
    .pll_req_o(pll_req_o),
    .pll_freq_sel_o(pll_freq_sel_o),
    .cur_freq_index_o(cur_freq_index_o),
    .busy_o(busy_o)
  );

  assign outv = {freq_change_ready_o, freq_change_done_o, freq_change_error_o,
                 watch_dog_timeout_o, pll_req_o, busy_o};

  // Cycle 0 is the cycle in which the start edge is presented. mc_idle_i,
  // pll_freq_chng_done_i and pll_lock_i are high from cycles a, b, c onward.
  task automatic model_seq(input int idx, input int a, input int b, input int c,
                           input int rst_at, input int cur_in,
                           output int end_t, output int cur_out);
    int t0, r, t1, t2;
    for (int t = 0; t < MAXT; t++) exp_v[t] = '0;
    cur_out = cur_in;
    if (idx >= NB_FREQ) begin
      exp_v[1] = V_ERR | V_BUSY;
      end_t = 1;
    end else if (idx == cur_in) begin
      exp_v[1] = V_DONE | V_BUSY;
      end_t = 1;
      cur_out = idx;
    end else begin
      t0 = (a > QUIESCE_CYC) ? a : QUIESCE_CYC;   // last quiesce cycle
      r  = t0 + 1;                                 // ready cycle
      t1 = (b > r + 1) ? b : r + 1;                // last wait-for-software cycle
      t2 = (c > t1 + 1) ? c : t1 + 1;              // last relock cycle
      end_t = (t2 <= WDT_CYC) ? t2 + 1 : WDT_CYC + 1;
      for (int t = 1; t <= end_t; t++) exp_v[t] = exp_v[t] | V_BUSY;
      if (r <= WDT_CYC) exp_v[r] = exp_v[r] | V_READY;
      for (int t = t1 + 1; (t <= t2) && (t <= WDT_CYC); t++) exp_v[t] = exp_v[t] | V_REQ;
      if (t2 <= WDT_CYC) begin
        exp_v[end_t] = exp_v[end_t] | V_DONE;
        cur_out = idx;
      end else begin
        exp_v[end_t] = exp_v[end_t] | V_ERR | V_TO;
      end
    end
    if ((rst_at >= 0) && (rst_at < end_t)) begin
      for (int t = rst_at + 1; t < MAXT; t++) exp_v[t] = '0;
      end_t = rst_at;
      cur_out = 0;
    end
  endtask

  task automatic drive_seq(input int idx, input int a, input int b, input int c,
                           input int rst_at, input int noisy_to, input int ncyc);
    for (int t = 0; t < ncyc; t++) begin
      @(negedge pclk_i);
      obs_v[t] = outv;
      mc_idle_i            = (t >= a);
      pll_freq_chng_done_i = (t >= b);
      pll_lock_i           = (t >= c);
      prst_i               = (t == rst_at);
      if (t == 0) begin
        start_freq_change_i = 1'b1;
        freq_index_i        = FIDX_W'(idx);
      end else if (t <= noisy_to) begin
        start_freq_change_i = 1'($urandom_range(0, 1));
        freq_index_i        = FIDX_W'($urandom_range(0, NB_FREQ - 1));
      end else begin
        start_freq_change_i = 1'b0;
      end
    end
    @(negedge pclk_i);
    prst_i = 1'b0;
    start_freq_change_i = 1'b0;
    mc_idle_i = 1'b0;
    pll_freq_chng_done_i = 1'b0;
    pll_lock_i = 1'b0;
  endtask

  task automatic test_reset();
    prst_i = 1'b1;
    repeat (2) @(negedge pclk_i);
    n_checks++; if (outv !== 6'b0) $display("FAIL reset_outputs got %b want 000000", outv); else n_pass++;
    n_checks++; if (cur_freq_index_o !== '0) $display("FAIL reset_cur got %0d want 0", cur_freq_index_o); else n_pass++;
    n_checks++; if (pll_freq_sel_o !== '0) $display("FAIL reset_sel got %0d want 0", pll_freq_sel_o); else n_pass++;
    prst_i = 1'b0;
    @(negedge pclk_i);
    n_checks++; if (outv !== 6'b0) $display("FAIL reset_release got %b want 000000", outv); else n_pass++;
    m_cur = 0;
  endtask

  task automatic test_nominal();
    int e, co, b, c;
    b = 1 + QUIESCE_CYC + 10;
    c = b + 3;
    model_seq(5, 0, b, c, -1, m_cur, e, co);
    drive_seq(5, 0, b, c, -1, 0, e + 3);
    for (int t = 0; t < e + 3; t++) begin
      n_checks++;
      if (obs_v[t] !== exp_v[t]) $display("FAIL nominal t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
      else n_pass++;
    end
    n_checks++;
    if (obs_v[1 + QUIESCE_CYC] !== (V_READY | V_BUSY))
      $display("FAIL nominal_ready_time got %b want %b", obs_v[1 + QUIESCE_CYC], V_READY | V_BUSY);
    else n_pass++;
    n_checks++; if (cur_freq_index_o !== 5'd5) $display("FAIL nominal_cur got %0d want 5", cur_freq_index_o); else n_pass++;
    n_checks++; if (pll_freq_sel_o !== 5'd5) $display("FAIL nominal_sel got %0d want 5", pll_freq_sel_o); else n_pass++;
    m_cur = co;
  endtask

  task automatic test_same_index();
    int e, co;
    model_seq(m_cur, 0, 0, 0, -1, m_cur, e, co);
    drive_seq(m_cur, 0, 0, 0, -1, 0, e + 3);
    for (int t = 0; t < e + 3; t++) begin
      n_checks++;
      if (obs_v[t] !== exp_v[t]) $display("FAIL same_index t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
      else n_pass++;
    end
    n_checks++; if (obs_v[1] !== (V_DONE | V_BUSY)) $display("FAIL same_index_done got %b want %b", obs_v[1], V_DONE | V_BUSY); else n_pass++;
    n_checks++; if (cur_freq_index_o !== FIDX_W'(m_cur)) $display("FAIL same_index_cur got %0d want %0d", cur_freq_index_o, m_cur); else n_pass++;
    m_cur = co;
  endtask

  task automatic test_busy_start();
    int e, co, nd;
    model_seq(3, 0, 7, 9, -1, m_cur, e, co);
    drive_seq(3, 0, 7, 9, -1, e, e + 3);
    nd = 0;
    for (int t = 0; t < e + 3; t++) begin
      if (obs_v[t][4]) nd++;
      n_checks++;
      if (obs_v[t] !== exp_v[t]) $display("FAIL busy_start t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
      else n_pass++;
    end
    n_checks++; if (nd !== 1) $display("FAIL busy_start_done_count got %0d want 1", nd); else n_pass++;
    n_checks++; if (cur_freq_index_o !== 5'd3) $display("FAIL busy_start_cur got %0d want 3", cur_freq_index_o); else n_pass++;
    m_cur = co;
  endtask

  task automatic test_invalid();
    int e, co;
    logic [FIDX_W-1:0] sel_before;
    sel_before = pll_freq_sel_o;
    model_seq(9, 0, 0, 0, -1, m_cur, e, co);
    drive_seq(9, 0, 0, 0, -1, 0, e + 3);
    for (int t = 0; t < e + 3; t++) begin
      n_checks++;
      if (obs_v[t] !== exp_v[t]) $display("FAIL invalid t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
      else n_pass++;
    end
    n_checks++; if (obs_v[1] !== (V_ERR | V_BUSY)) $display("FAIL invalid_err got %b want %b", obs_v[1], V_ERR | V_BUSY); else n_pass++;
    n_checks++; if (cur_freq_index_o !== FIDX_W'(m_cur)) $display("FAIL invalid_cur got %0d want %0d", cur_freq_index_o, m_cur); else n_pass++;
    n_checks++; if (pll_freq_sel_o !== sel_before) $display("FAIL invalid_sel got %0d want %0d", pll_freq_sel_o, sel_before); else n_pass++;
    m_cur = co;
  endtask

  task automatic test_watchdog();
    int e, co, nreq;
    model_seq(6, 0, 1000, 1000, -1, m_cur, e, co);
    drive_seq(6, 0, 1000, 1000, -1, 0, e + 3);
    nreq = 0;
    for (int t = 0; t < e + 3; t++) begin
      if (obs_v[t][1]) nreq++;
      n_checks++;
      if (obs_v[t] !== exp_v[t]) $display("FAIL watchdog t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
      else n_pass++;
    end
    n_checks++;
    if (obs_v[WDT_CYC + 1] !== (V_ERR | V_TO | V_BUSY))
      $display("FAIL watchdog_expiry got %b want %b", obs_v[WDT_CYC + 1], V_ERR | V_TO | V_BUSY);
    else n_pass++;
    n_checks++; if (nreq !== 0) $display("FAIL watchdog_pll_req got %0d cycles want 0", nreq); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL watchdog_idle_after got busy=%b want 0", busy_o); else n_pass++;
    n_checks++; if (cur_freq_index_o !== FIDX_W'(m_cur)) $display("FAIL watchdog_cur got %0d want %0d", cur_freq_index_o, m_cur); else n_pass++;
    m_cur = co;
  endtask

  task automatic test_race();
    int e, co;
    model_seq(1, 0, 6, WDT_CYC, -1, m_cur, e, co);
    drive_seq(1, 0, 6, WDT_CYC, -1, 0, e + 3);
    for (int t = 0; t < e + 3; t++) begin
      n_checks++;
      if (obs_v[t] !== exp_v[t]) $display("FAIL race t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
      else n_pass++;
    end
    n_checks++;
    if (obs_v[WDT_CYC + 1] !== (V_DONE | V_BUSY))
      $display("FAIL race_done got %b want %b", obs_v[WDT_CYC + 1], V_DONE | V_BUSY);
    else n_pass++;
    n_checks++; if (cur_freq_index_o !== 5'd1) $display("FAIL race_cur got %0d want 1", cur_freq_index_o); else n_pass++;
    m_cur = co;
  endtask

  task automatic test_reset_mid();
    int e, co;
    model_seq(4, 0, 8, 1000, 12, m_cur, e, co);
    drive_seq(4, 0, 8, 1000, 12, 0, e + 3);
    for (int t = 0; t < e + 3; t++) begin
      n_checks++;
      if (obs_v[t] !== exp_v[t]) $display("FAIL reset_mid t=%0d got %b want %b", t, obs_v[t], exp_v[t]);
      else n_pass++;
    end
    n_checks++; if (obs_v[12] !== (V_REQ | V_BUSY)) $display("FAIL reset_mid_relock got %b want %b", obs_v[12], V_REQ | V_BUSY); else n_pass++;
    n_checks++; if (obs_v[13] !== 6'b0) $display("FAIL reset_mid_after got %b want 000000", obs_v[13]); else n_pass++;
    n_checks++; if (cur_freq_index_o !== '0) $display("FAIL reset_mid_cur got %0d want 0", cur_freq_index_o); else n_pass++;
    n_checks++; if (pll_freq_sel_o !== '0) $display("FAIL reset_mid_sel got %0d want 0", pll_freq_sel_o); else n_pass++;
    m_cur = co;
  endtask

  task automatic test_start_held_reset();
    @(negedge pclk_i);
    prst_i = 1'b1;
    start_freq_change_i = 1'b1;
    freq_index_i = 5'd5;
    mc_idle_i = 1'b1;
    repeat (2) @(negedge pclk_i);
    prst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk_i);
      n_checks++;
      if (outv !== 6'b0) $display("FAIL start_held_reset cyc=%0d got %b want 000000", i, outv);
      else n_pass++;
    end
    start_freq_change_i = 1'b0;
    mc_idle_i = 1'b0;
    @(negedge pclk_i);
    m_cur = 0;
  endtask

  task automatic test_random();
    int e, co, idx, a, b, c, noisy;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, NB_FREQ + 3);
      if ($urandom_range(0, 5) == 0) idx = m_cur;
      a = $urandom_range(0, 10);
      b = $urandom_range(0, 50);
      c = $urandom_range(0, 75);
      model_seq(idx, a, b, c, -1, m_cur, e, co);
      noisy = ($urandom_range(0, 1) == 1) ? e : 0;
      drive_seq(idx, a, b, c, -1, noisy, e + 3);
      for (int t = 0; t < e + 3; t++) begin
        n_checks++;
        if (obs_v[t] !== exp_v[t])
          $display("FAIL random n=%0d idx=%0d a=%0d b=%0d c=%0d t=%0d got %b want %b",
                   n, idx, a, b, c, t, obs_v[t], exp_v[t]);
        else n_pass++;
      end
      n_checks++;
      if (cur_freq_index_o !== FIDX_W'(co))
        $display("FAIL random_cur n=%0d got %0d want %0d", n, cur_freq_index_o, co);
      else n_pass++;
      m_cur = co;
    end
  endtask

  initial begin
    prst_i = 1'b1;
    start_freq_change_i = 1'b0;
    freq_index_i = '0;
    pll_freq_chng_done_i = 1'b0;
    mc_idle_i = 1'b0;
    pll_lock_i = 1'b0;
    test_reset();
    test_nominal();
    test_same_index();
    test_busy_start();
    test_invalid();
    test_watchdog();
    test_race();
    test_reset_mid();
    test_start_held_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish before time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/freq_change_sequencer.md
FREQ_CHANGE_SEQUENCER -- requirements
Module: freq_change_sequencer

Interface
REQ-001 The block SHALL have parameter NB_FREQ, default 8, giving the number of legal frequency indices (0..NB_FREQ-1).
REQ-002 The block SHALL have parameter FIDX_W, default 5, giving the frequency index width.
REQ-003 The block SHALL have parameter QUIESCE_CYC, default 4, giving the minimum drain cycles before ready.
REQ-004 The block SHALL have parameter WDT_CYC, default 64, giving the watchdog limit in cycles per sequence.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have port pclk_i, input, 1 bit: the APB-domain clock; all logic is on its rising edge.
REQ-007 The block SHALL have port prst_i, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have port start_freq_change_i, input, 1 bit: start request from the APB slave; the request is its rising edge.
REQ-009 The block SHALL have port freq_index_i, input, FIDX_W bits: target index, sampled on the start edge.
REQ-010 The block SHALL have port pll_freq_chng_done_i, input, 1 bit: software permission to relock the PLL (level).
REQ-011 The block SHALL have port mc_idle_i, input, 1 bit: the memory controller has no outstanding traffic.
REQ-012 The block SHALL have port pll_lock_i, input, 1 bit: the PLL is locked at the requested frequency.
REQ-013 The block SHALL have port freq_change_ready_o, output, 1 bit: one-cycle pulse to the slave meaning quiesced and ready for PLL reprogramming.
REQ-014 The block SHALL have port freq_change_done_o, output, 1 bit: one-cycle pulse meaning the sequence completed.
REQ-015 The block SHALL have port freq_change_error_o, output, 1 bit: one-cycle pulse meaning the sequence aborted.
REQ-016 The block SHALL have port watch_dog_timeout_o, output, 1 bit: one-cycle pulse meaning the watchdog expired.
REQ-017 The block SHALL have port pll_req_o, output, 1 bit: level request to the PLL to switch to pll_freq_sel_o.
REQ-018 The block SHALL have port pll_freq_sel_o, output, FIDX_W bits: the latched target index.
REQ-019 The block SHALL have port cur_freq_index_o, output, FIDX_W bits: the current operating index.
REQ-020 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, QUIESCE, READY, WAIT_PLL, RELOCK, DONE and ERR.
REQ-022 Start edge detection SHALL use a registered copy of start_freq_change_i; an edge seen in cycle N makes the state change in N+1.
REQ-023 Start edges arriving while busy_o=1 SHALL be ignored, with no queuing.
REQ-024 On a start edge in IDLE with freq_index_i>=NB_FREQ, the FSM SHALL go to ERR; the index is not latched.
REQ-025 On a start edge in IDLE with freq_index_i==cur_freq_index_o, the FSM SHALL go directly to DONE, with no ready pulse and no pll_req_o.
REQ-026 Otherwise, on a start edge in IDLE, the FSM SHALL latch the index into pll_freq_sel_o, clear the quiesce and watchdog counters, and go to QUIESCE.
REQ-027 The FSM SHALL leave QUIESCE for READY in the first cycle where the quiesce counter is >=QUIESCE_CYC-1 and mc_idle_i=1; the counter saturates.
REQ-028 READY SHALL last exactly one cycle with freq_change_ready_o=1, then go to WAIT_PLL.
REQ-029 In WAIT_PLL, pll_freq_chng_done_i=1 SHALL move the FSM to RELOCK; pll_req_o is high from RELOCK entry until RELOCK exit.
REQ-030 In RELOCK, pll_lock_i=1 SHALL move the FSM to DONE.
REQ-031 DONE SHALL last one cycle with freq_change_done_o=1, update cur_freq_index_o to pll_freq_sel_o, and then return to IDLE.
REQ-032 The watchdog counter SHALL increment every cycle in QUIESCE, READY, WAIT_PLL and RELOCK.
REQ-033 The watchdog counter width SHALL be clog2(WDT_CYC+1), and it SHALL saturate.
REQ-034 When the watchdog count reaches WDT_CYC-1 in those states, the FSM SHALL go to ERR with watch_dog_timeout_o=1 in the ERR cycle.
REQ-035 ERR SHALL last one cycle with freq_change_error_o=1, deassert pll_req_o, leave cur_freq_index_o unchanged, and then return to IDLE.
REQ-036 When a transition to DONE and a watchdog expiry fall in the same cycle, DONE SHALL win.
REQ-037 watch_dog_timeout_o SHALL never assert on an invalid-index error.
REQ-038 All outputs SHALL be registered.
REQ-039 At most one of ready, done and error SHALL be high in any cycle.

Reset
REQ-040 While prst_i=1 at a clock edge, the block SHALL enter IDLE, clear every counter and the edge-detect register, and drive all pulse outputs, pll_req_o and busy_o to 0.
REQ-041 Under reset, pll_freq_sel_o and cur_freq_index_o SHALL be 0.
REQ-042 Reset in mid-sequence SHALL abort with no done or error pulse.
REQ-043 If start_freq_change_i is held high through the release of reset, this SHALL NOT count as an edge.

Verification
REQ-044 Nominal: cur=0, index=5, mc_idle_i=1, pll_freq_chng_done_i 10 cycles after ready, pll_lock_i 3 cycles later -> ready at start+1+QUIESCE_CYC, one done pulse, cur_freq_index_o=5, pll_req_o high only in RELOCK.
REQ-045 Invalid index: index=9 with NB_FREQ=8 -> error pulse 1 cycle after the start edge; no ready, no timeout, cur unchanged.
REQ-046 Watchdog: pll_freq_chng_done_i never asserted -> error and timeout pulses together after WDT_CYC busy cycles; pll_req_o stays 0; IDLE afterwards.
REQ-047 Same index plus busy start: start with index=cur -> done pulse only; a second start edge during a busy sequence -> ignored, exactly one done.
REQ-048 Reset mid-RELOCK: prst_i=1 for 1 cycle -> next cycle all outputs 0, IDLE, cur_freq_index_o=0, no done or error pulse.
REQ-049 Race: pll_lock_i rises in the cycle the watchdog expires -> done pulse, no error.
